// File: rtl/blackbox_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | blackbox_queue: parameterized ready/valid circular-buffer FIFO.            |
// | Optional BLACKBOX_QUEUE_FLOW_EN: empty-queue combinational pass-through.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module blackbox_queue #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enq_valid,
  output logic                         enq_ready,
  input  logic [WIDTH-1:0]             enq_bits,
  output logic                         deq_valid,
  input  logic                         deq_ready,
  output logic [WIDTH-1:0]             deq_bits,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] c_depth_cnt = CW'(DEPTH);
  localparam logic [CW-1:0] c_cnt_one   = CW'(1);
  localparam logic [PW-1:0] c_last_ptr  = PW'(DEPTH - 1);
  localparam logic [PW-1:0] c_ptr_one   = PW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_empty;
  logic w_full;
  logic w_store_valid;
  logic w_wr_en;
  logic w_rd_en;

  assign w_empty       = (r_count == '0);
  assign w_full        = (r_count == c_depth_cnt);
  assign w_store_valid = !w_empty;
  assign count         = r_count;

  always_comb begin
    enq_ready = !w_full;
    deq_valid = w_store_valid;
    deq_bits  = w_store_valid ? r_mem[r_rd_ptr] : '0;
`ifdef BLACKBOX_QUEUE_FLOW_EN
    // Empty queue presents the producer's entry directly to the consumer.
    if (w_empty) begin
      deq_valid = enq_valid;
      deq_bits  = enq_valid ? enq_bits : '0;
    end
`endif
  end

`ifdef BLACKBOX_QUEUE_FLOW_EN
  // A pass-through transfer touches neither storage nor pointers.
  assign w_wr_en = enq_valid & enq_ready & !(w_empty & deq_ready);
`else
  assign w_wr_en = enq_valid & enq_ready;
`endif
  assign w_rd_en = w_store_valid & deq_ready;

  always_ff @(posedge clock) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= enq_bits;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + c_ptr_one;
      end
      if (w_rd_en) begin
        r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + c_ptr_one;
      end
      if (w_wr_en && !w_rd_en) begin
        r_count <= r_count + c_cnt_one;
      end else if (w_rd_en && !w_wr_en) begin
        r_count <= r_count - c_cnt_one;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_blackbox_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_blackbox_queue: directed self-checking bench for blackbox_queue.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_blackbox_queue;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic             clock;
  logic             reset;
  logic             enq_valid;
  logic             enq_ready;
  logic [WIDTH-1:0] enq_bits;
  logic             deq_valid;
  logic             deq_ready;
  logic [WIDTH-1:0] deq_bits;
  logic [2:0]       count;

  int errors = 0;
  int checks = 0;

  blackbox_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready),
    .enq_bits  (enq_bits),
    .deq_valid (deq_valid),
    .deq_ready (deq_ready),
    .deq_bits  (deq_bits),
    .count     (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [15:0] vals [4];
    logic [15:0] exp_head;
    vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333; vals[3] = 16'h4444;

    reset = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0; enq_bits = '0;
    #2 reset = 1'b1;
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_deq_valid", 64'(deq_valid), 64'd0);
    check("rst_enq_ready", 64'(enq_ready), 64'd1);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_count", 64'(count), 64'd0);
      check("idle_deq_valid", 64'(deq_valid), 64'd0);
      check("idle_deq_bits", 64'(deq_bits), 64'd0);
      check("idle_enq_ready", 64'(enq_ready), 64'd1);
    end

    // Fill to full
    for (int i = 0; i < 4; i++) begin
      enq_valid = 1'b1; enq_bits = vals[i];
      step();
      check("fill_count", 64'(count), 64'(i + 1));
    end
    check("full_enq_ready", 64'(enq_ready), 64'd0);
    enq_bits = 16'h9999;
    step();
    check("full_blocked_count", 64'(count), 64'd4);
    check("full_head", 64'(deq_bits), 64'h1111);

    // Full with both sides active: only dequeue fires
    enq_bits = 16'h5555; deq_ready = 1'b1;
    #1;
    check("both_full_deq_bits", 64'(deq_bits), 64'h1111);
    step();
    check("both_full_count", 64'(count), 64'd3);
    deq_ready = 1'b0;
    step();
    check("refill_count", 64'(count), 64'd4);
    enq_valid = 1'b0;

    // Drain: 0x5555 must appear exactly once, after 0x4444
    deq_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_head = (i < 3) ? vals[i + 1] : 16'h5555;
      check("drain_bits", 64'(deq_bits), 64'(exp_head));
      step();
      check("drain_count", 64'(count), 64'(3 - i));
    end
    check("drained_deq_valid", 64'(deq_valid), 64'd0);
    check("drained_deq_bits", 64'(deq_bits), 64'd0);

    // Half full, then streaming with both handshakes held high
    deq_ready = 1'b0; enq_valid = 1'b1;
    enq_bits = 16'd100; step();
    enq_bits = 16'd101; step();
    check("half_count", 64'(count), 64'd2);
    deq_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      enq_bits = 16'(i);
      #1;
      exp_head = (i < 2) ? 16'(100 + i) : 16'(i - 2);
      check("stream_bits", 64'(deq_bits), 64'(exp_head));
      step();
      check("stream_count", 64'(count), 64'd2);
    end
    enq_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("stream_tail_bits", 64'(deq_bits), 64'(8 + i));
      step();
    end
    check("stream_end_count", 64'(count), 64'd0);

    // Load 3, then asynchronous reset mid-cycle
    deq_ready = 1'b0; enq_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      enq_bits = 16'(16'hA0 + i);
      step();
    end
    enq_valid = 1'b0;
    check("preload_count", 64'(count), 64'd3);
    #3 reset = 1'b1;
    #1;
    check("async_rst_count", 64'(count), 64'd0);
    check("async_rst_deq_valid", 64'(deq_valid), 64'd0);
    check("async_rst_deq_bits", 64'(deq_bits), 64'd0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    enq_valid = 1'b1; enq_bits = 16'hBEEF;
    step();
    enq_valid = 1'b0;
    #1;
    check("post_rst_count", 64'(count), 64'd1);
    check("post_rst_deq_valid", 64'(deq_valid), 64'd1);
    check("post_rst_deq_bits", 64'(deq_bits), 64'hBEEF);
    deq_ready = 1'b1;
    step();
    check("post_rst_drain", 64'(count), 64'd0);

    // Empty queue, producer and consumer both active
    enq_valid = 1'b1; enq_bits = 16'hCAFE; deq_ready = 1'b1;
    #1;
    check("flow_enq_ready", 64'(enq_ready), 64'd1);
`ifdef BLACKBOX_QUEUE_FLOW_EN
    check("flow_deq_valid", 64'(deq_valid), 64'd1);
    check("flow_deq_bits", 64'(deq_bits), 64'hCAFE);
    step();
    enq_valid = 1'b0;
    #1;
    check("flow_count", 64'(count), 64'd0);
    check("flow_after_valid", 64'(deq_valid), 64'd0);
`else
    check("noflow_deq_valid", 64'(deq_valid), 64'd0);
    check("noflow_deq_bits", 64'(deq_bits), 64'd0);
    step();
    enq_valid = 1'b0;
    #1;
    check("noflow_count", 64'(count), 64'd1);
    check("noflow_next_valid", 64'(deq_valid), 64'd1);
    check("noflow_next_bits", 64'(deq_bits), 64'hCAFE);
    step();
    check("noflow_drain", 64'(count), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/blackbox_queue.md
Name: blackbox_queue

Overview:
- Parameterized ready/valid FIFO, provided as a Verilog blackbox for the Chisel BlackBox test suite.
- Sits between a Chisel-side producer (e.g. a counter or the blackbox arithmetic outputs) and a Chisel-side checker.
- Exercises blackbox parameter passing, clock/reset connection and decoupled handshakes across the blackbox boundary.
- Storage is a circular buffer with read/write pointers and an occupancy counter.

Parameters:
- WIDTH, 16, data width of enq_bits/deq_bits in bits; legal range 1..64.
- DEPTH, 4, number of entries; any integer >= 1, not restricted to powers of two.

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- enq_valid  input  1  producer presents enq_bits.
- enq_ready  output  1  queue can accept an entry this cycle.
- enq_bits  input  WIDTH  data to enqueue.
- deq_valid  output  1  deq_bits holds the head entry.
- deq_ready  input  1  consumer accepts the head entry.
- deq_bits  output  WIDTH  head entry; 0 whenever deq_valid=0.
- count  output  $clog2(DEPTH+1), min 1  current occupancy, 0..DEPTH.

Behaviour:
- Interface: one clock, `clock`; reset `reset` is asynchronous and active-high. Assertion immediately clears wr_ptr, rd_ptr and count to 0, independent of clock.
- During and after reset:
  - count=0, deq_valid=0, deq_bits=0, enq_ready=1.
  - Storage contents are not cleared and are never observable while empty.
- Handshake:
  - Enqueue fires on posedge when enq_valid & enq_ready.
  - Dequeue fires on posedge when deq_valid & deq_ready.
  - enq_valid/deq_ready may be held high; they need not deassert between transfers.
- Flags (combinational from registered state):
  - enq_ready = (count != DEPTH).
  - deq_valid = (count != 0).
  - deq_bits = mem[rd_ptr] when deq_valid, else 0.
- Latency: an entry enqueued at edge N is visible on deq with deq_valid=1 after edge N. This is one cycle; there is no combinational path from enq to deq.
- Pointer wrap: each pointer increments by 1 on its fire and wraps from DEPTH-1 to 0 by explicit compare, not by bit truncation.
- count update:
  - +1 on enqueue fire only.
  - -1 on dequeue fire only.
  - Unchanged when both or neither fire.
- Simultaneous events:
  - Full (count=DEPTH) with enq_valid & deq_ready: only the dequeue fires, because enq_ready=0. Next count=DEPTH-1.
  - Empty with enq_valid & deq_ready: only the enqueue fires. Next count=1.
  - 0<count<DEPTH with both active: both fire, count holds, both pointers advance.
- DEPTH=1: enq_ready and deq_valid are strict complements; throughput is one entry per 2 cycles.
- Inputs are sampled only at posedge; X on enq_bits while enq_valid=0 has no effect.
- Reset mid-operation: all queued entries are discarded. After reset deasserts, the first dequeued value is the first value enqueued after reset.

Optional Feature:
- Macro: BLACKBOX_QUEUE_FLOW_EN.
- Defined (flow mode), when count=0:
  - deq_valid = enq_valid and deq_bits = enq_bits combinationally.
  - If deq_ready=1 the entry passes through the same cycle; count and both pointers stay unchanged, and no write to storage.
  - If deq_ready=0 the entry is stored normally.
  - Behaviour when count>0 is identical to non-flow mode.
- Undefined: the one-cycle latency described above; no combinational enq->deq path exists.

Test Plan:
- Reset, then idle 3 cycles -> count=0, deq_valid=0, deq_bits=0, enq_ready=1 every cycle.
- DEPTH=4, WIDTH=16: enqueue 0x1111,0x2222,0x3333,0x4444 with deq_ready=0 -> count=4, enq_ready=0. A fifth enq_valid is not accepted. Then drain with deq_ready=1 -> values dequeued in order, count 3,2,1,0.
- Full queue with enq_valid=1 (0x5555) & deq_ready=1 for 1 cycle -> 0x1111 dequeued, count=3, 0x5555 not stored. Next cycle enq accepted, count=4.
- Half-full (count=2) with enq_valid & deq_ready held high for 10 cycles, enq_bits = incrementing 0..9 -> count stays 2; both pointers wrap at least twice; output sequence is contiguous with no loss or duplication.
- Load 3 entries, assert reset asynchronously mid-cycle for 2 cycles, then enqueue 0xBEEF -> count=0 immediately on reset. After deassert, next deq_bits=0xBEEF with count=1.
- BLACKBOX_QUEUE_FLOW_EN defined, empty, enq_valid=1 enq_bits=0xCAFE deq_ready=1 -> deq_valid=1 and deq_bits=0xCAFE in the same cycle; count stays 0. Without the macro: deq_valid=0 that cycle, 0xCAFE appears next cycle.
